strip_conv_scheduler: RTL and testbench

Frame-level controller for the eight segmented-frame strip convolution units. It resets the units, loads the shared 3x3 kernel from kernel BRAM, and broadcasts the coefficients. It then starts all strips, waits for every strip to finish, and drains each strip's output memory through one shared address bus into a single back-pressured pixel stream.

---
 rtl/strip_conv_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_strip_conv_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strip_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : strip_conv_scheduler
// Description : Frame controller for the strip convolution units. It resets
//               the units, loads and broadcasts the 3x3 kernel, starts all
//               strips, then drains their results into one pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
module strip_conv_scheduler #(
  parameter int NUM_STRIPS  = 8,
  parameter int STRIP_WORDS = 6216,
  parameter int KRD_LAT     = 1,
  parameter int OUT_LAT     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  output logic                    busy,
  output logic                    frame_done,
  output logic [3:0]              kernel_addr,
  output logic                    kernel_rd_en,
  input  logic [8:0]              kernel_rdata,
  output logic [80:0]             kernel_flat,
  output logic                    kernel_read_complete,
  output logic                    strip_rst,
  output logic [NUM_STRIPS-1:0]   strip_start,
  input  logic [NUM_STRIPS-1:0]   strip_done,
  output logic [15:0]             strip_addr,
  input  logic [9*NUM_STRIPS-1:0] strip_out,
  output logic                    pix_valid,
  output logic [8:0]              pix_data,
  output logic                    pix_last,
  input  logic                    pix_ready
);

  localparam int c_SIDX_W = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SRST, ST_KLOAD, ST_KWAIT, ST_RUN, ST_READOUT, ST_FINISH
  } state_t;

  state_t                r_state, w_state_n;
  logic [3:0]            r_cnt;
  logic [KRD_LAT-1:0]    r_kv;
  logic [3:0]            r_kidx [KRD_LAT];
  logic [80:0]           r_kflat;
  logic [NUM_STRIPS-1:0] r_done;
  logic [c_SIDX_W-1:0]   r_s;
  logic [15:0]           r_w;
  logic                  r_issued_all;
  logic [OUT_LAT-1:0]    r_tv, r_tl;
  logic [c_SIDX_W-1:0]   r_ts [OUT_LAT];
  logic [9:0]            r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wp, r_rp;
  logic [c_CNT_W-1:0]    r_fcnt;

  logic                  w_last_word, w_issue, w_push, w_pop, w_fvalid;
  logic [8:0]            w_slice;
  int                    w_inflight;

  assign w_fvalid    = (r_fcnt != '0);
  assign w_pop       = w_fvalid && pix_ready;
  assign w_push      = r_tv[OUT_LAT-1];
  assign w_last_word = (r_s == c_SIDX_W'(NUM_STRIPS - 1)) && (r_w == 16'(STRIP_WORDS - 1));

  // Issue is throttled so every in-flight word is guaranteed a FIFO slot.
  always_comb begin
    w_inflight = 0;
    for (int i = 0; i < OUT_LAT; i++) w_inflight = w_inflight + int'(r_tv[i]);
    w_issue = (r_state == ST_READOUT) && !r_issued_all &&
              ((int'(r_fcnt) + w_inflight) < FIFO_DEPTH);
  end

  always_comb begin
    w_slice = '0;
    for (int n = 0; n < NUM_STRIPS; n++)
      if (r_ts[OUT_LAT-1] == c_SIDX_W'(n)) w_slice = strip_out[9*n +: 9];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n            = r_state;
    busy                 = (r_state != ST_IDLE);
    frame_done           = 1'b0;
    kernel_rd_en         = 1'b0;
    kernel_addr          = '0;
    kernel_read_complete = 1'b0;
    strip_rst            = 1'b0;
    strip_start          = '0;
    strip_addr           = '0;
    case (r_state)
      ST_IDLE:  if (frame_start) w_state_n = ST_SRST;
      ST_SRST: begin
        strip_rst = 1'b1;
        if (r_cnt == 4'd1) w_state_n = ST_KLOAD;
      end
      ST_KLOAD: begin
        kernel_rd_en = 1'b1;
        kernel_addr  = r_cnt;
        if (r_cnt == 4'd8) w_state_n = ST_KWAIT;
      end
      ST_KWAIT: if (r_cnt == 4'(KRD_LAT - 1)) w_state_n = ST_RUN;
      ST_RUN: begin
        kernel_read_complete = 1'b1;
        strip_start          = '1;
        if (&(r_done | strip_done)) w_state_n = ST_READOUT;
      end
      ST_READOUT: begin
        kernel_read_complete = 1'b1;
        strip_start          = '1;
        strip_addr           = r_w;
        if (w_pop && r_mem[r_rp][9]) w_state_n = ST_FINISH;
      end
      ST_FINISH: begin
        frame_done = 1'b1;
        w_state_n  = ST_IDLE;
      end
      default:  w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_kv         <= '0;
      r_kflat      <= '0;
      r_done       <= '0;
      r_s          <= '0;
      r_w          <= '0;
      r_issued_all <= 1'b0;
      r_tv         <= '0;
      r_tl         <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_fcnt       <= '0;
      for (int i = 0; i < KRD_LAT; i++) r_kidx[i] <= '0;
      for (int i = 0; i < OUT_LAT; i++) r_ts[i] <= '0;
    end else begin
      r_cnt <= (w_state_n != r_state) ? 4'd0 : r_cnt + 4'd1;

      // Read-latency-matched index pipeline steering each coefficient to its slot.
      r_kv[0]   <= (r_state == ST_KLOAD);
      r_kidx[0] <= r_cnt;
      for (int i = 1; i < KRD_LAT; i++) begin
        r_kv[i]   <= r_kv[i-1];
        r_kidx[i] <= r_kidx[i-1];
      end
      for (int k = 0; k < 9; k++)
        if (r_kv[KRD_LAT-1] && (r_kidx[KRD_LAT-1] == 4'(k))) r_kflat[9*k +: 9] <= kernel_rdata;

      if (r_state == ST_SRST) r_done <= '0;
      else if (r_state == ST_RUN) r_done <= r_done | strip_done;

      if (r_state == ST_SRST) begin
        r_s          <= '0;
        r_w          <= '0;
        r_issued_all <= 1'b0;
        r_tv         <= '0;
        r_wp         <= '0;
        r_rp         <= '0;
        r_fcnt       <= '0;
      end else begin
        r_tv[0] <= w_issue;
        r_tl[0] <= w_last_word;
        r_ts[0] <= r_s;
        for (int i = 1; i < OUT_LAT; i++) begin
          r_tv[i] <= r_tv[i-1];
          r_tl[i] <= r_tl[i-1];
          r_ts[i] <= r_ts[i-1];
        end
        if (w_issue) begin
          if (w_last_word) r_issued_all <= 1'b1;
          if (r_w == 16'(STRIP_WORDS - 1)) begin
            r_w <= '0;
            if (!w_last_word) r_s <= r_s + 1'b1;
          end else begin
            r_w <= r_w + 16'd1;
          end
        end
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_pop)  r_rp <= r_rp + 1'b1;
        if (w_push && !w_pop)      r_fcnt <= r_fcnt + 1'b1;
        else if (!w_push && w_pop) r_fcnt <= r_fcnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {r_tl[OUT_LAT-1], w_slice};
  end

  assign kernel_flat = r_kflat;
  assign pix_valid   = w_fvalid;
  assign pix_data    = w_fvalid ? r_mem[r_rp][8:0] : 9'd0;
  assign pix_last    = w_fvalid ? r_mem[r_rp][9] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_strip_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_strip_conv_scheduler
// Description : Directed bench for strip_conv_scheduler with a stream scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_strip_conv_scheduler;

  localparam int NS = 2;
  localparam int SW = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          busy, frame_done;
  logic [3:0]    kernel_addr;
  logic          kernel_rd_en;
  logic [8:0]    kernel_rdata = '0;
  logic [80:0]   kernel_flat;
  logic          kernel_read_complete;
  logic          strip_rst;
  logic [NS-1:0] strip_start;
  logic [NS-1:0] strip_done;
  logic [15:0]   strip_addr;
  logic [9*NS-1:0] strip_out;
  logic          pix_valid;
  logic [8:0]    pix_data;
  logic          pix_last;
  logic          pix_ready = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int n_done   = 0;
  logic [9:0] sb[$];
  bit bp_mode = 1'b0;

  strip_conv_scheduler #(
    .NUM_STRIPS(NS), .STRIP_WORDS(SW), .KRD_LAT(1), .OUT_LAT(2), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .kernel_addr(kernel_addr), .kernel_rd_en(kernel_rd_en),
    .kernel_rdata(kernel_rdata), .kernel_flat(kernel_flat),
    .kernel_read_complete(kernel_read_complete), .strip_rst(strip_rst),
    .strip_start(strip_start), .strip_done(strip_done), .strip_addr(strip_addr),
    .strip_out(strip_out), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_last(pix_last), .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  // Kernel BRAM holding -4..4, one cycle read latency.
  always @(posedge clk) begin
    if (kernel_rd_en) kernel_rdata <= 9'(int'(kernel_addr) - 4);
  end

  // Strip units: address register then BRAM, unit n returns 10n+addr.
  logic [15:0] a_q = '0;
  logic [8:0]  so [NS];
  always @(posedge clk) begin
    a_q <= strip_addr;
    for (int n = 0; n < NS; n++) so[n] <= 9'(10*n + int'(a_q));
  end
  always_comb begin
    for (int n = 0; n < NS; n++) strip_out[9*n +: 9] = so[n];
  end

  task automatic check(input string tag, input logic [80:0] obs, input logic [80:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < SW; w++)
        sb.push_back({(s == NS-1 && w == SW-1), 9'(10*s + w)});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_kaddr"}, kernel_addr, 0);
    check({tag, "_krd_en"}, kernel_rd_en, 0);
    check({tag, "_kflat"}, kernel_flat, 0);
    check({tag, "_krc"}, kernel_read_complete, 0);
    check({tag, "_strip_rst"}, strip_rst, 0);
    check({tag, "_strip_start"}, strip_start, 0);
    check({tag, "_strip_addr"}, strip_addr, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_data"}, pix_data, 0);
    check({tag, "_pix_last"}, pix_last, 0);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_krc();
    int c = 0;
    while (kernel_read_complete !== 1'b1 && c < 50) begin
      @(posedge clk); #1; c++;
    end
    check("krc_timeout", (c < 50), 1);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (frame_done !== 1'b1 && c < 300) begin
      @(negedge clk); c++;
    end
    check({tag, "_done_timeout"}, (c < 300), 1);
    @(posedge clk); #1;
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic pulse_done_all();
    strip_done = '1;
    @(posedge clk); #1;
    strip_done = '0;
  endtask

  // Sink handshake driver: pattern 1,0,0,1 repeating under backpressure.
  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        pix_ready = pat[ph % 4];
        ph++;
      end else begin
        pix_ready = 1'b1;
      end
    end
  end

  // Stream monitor: scoreboard pops, stall stability and frame_done timing.
  initial begin
    bit stall_q = 1'b0;
    bit exp_done = 1'b0;
    bit exp_done_n;
    logic [8:0] pd_q = '0;
    logic pl_q = 1'b0;
    logic [9:0] item;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_q  = 1'b0;
        exp_done = 1'b0;
      end else begin
        exp_done_n = 1'b0;
        if (frame_done) n_done++;
        if (frame_done || exp_done) check("frame_done_timing", frame_done, exp_done);
        if (stall_q) begin
          check("hold_valid", pix_valid, 1);
          check("hold_data", pix_data, pd_q);
          check("hold_last", pix_last, pl_q);
        end
        if (pix_valid) check("fifo_occupancy", (dut.r_fcnt <= FD), 1);
        if (pix_valid && pix_ready) begin
          n_pop++;
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            item = sb.pop_front();
            check("pix_data", pix_data, item[8:0]);
            check("pix_last", pix_last, item[9]);
            if (item[9]) exp_done_n = 1'b1;
          end
        end
        exp_done = exp_done_n;
        stall_q  = pix_valid && !pix_ready;
        pd_q     = pix_data;
        pl_q     = pix_last;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int base;
    reset       = 1'b0;
    frame_start = 1'b0;
    strip_done  = '0;
    #1;
    check_idle_outputs("reset");
    #20;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Frame 1: kernel load timing, done ordering, stream order.
    push_frame();
    start_frame();
    for (int cy = 1; cy <= 13; cy++) begin
      check("busy", busy, 1);
      check("strip_rst", strip_rst, (cy <= 2));
      check("kernel_rd_en", kernel_rd_en, (cy >= 3 && cy <= 11));
      check("kernel_addr", kernel_addr, (cy >= 3 && cy <= 11) ? cy - 3 : 0);
      check("krc_rise", kernel_read_complete, (cy >= 13));
      if (cy < 13) begin
        @(posedge clk); #1;
      end
    end
    for (int k = 0; k < 9; k++) begin
      logic [8:0] e;
      e = 9'(k - 4);
      check("kernel_slot", kernel_flat[9*k +: 9], e);
    end
    strip_done = 2'b10;
    @(posedge clk); #1;
    strip_done = '0;
    repeat (4) begin
      check("wait_addr", strip_addr, 0);
      check("wait_valid", pix_valid, 0);
      check("wait_start", strip_start, 2'b11);
      @(posedge clk); #1;
    end
    check("wait_addr", strip_addr, 0);
    strip_done = 2'b01;
    c = 0;
    while (pix_valid !== 1'b1 && c < 20) begin
      @(posedge clk); #1; c++;
    end
    check("first_valid_latency", c, 4);
    wait_done("f1");
    strip_done = '0;

    // Frame 2: backpressure with a start request rejected during RUN.
    bp_mode = 1'b1;
    push_frame();
    start_frame();
    wait_krc();
    start_frame();
    pulse_done_all();
    wait_done("f2");
    bp_mode = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rejected_start_idle", busy, 0);

    // Frame 3: reset after the third pop.
    base = n_pop;
    push_frame();
    start_frame();
    wait_krc();
    pulse_done_all();
    c = 0;
    while (n_pop < base + 3 && c < 100) begin
      @(posedge clk); c++;
    end
    check("third_pop_timeout", (c < 100), 1);
    #1;
    reset = 1'b0;
    #1;
    check_idle_outputs("midreset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_valid", pix_valid, 0);
    reset = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("post_reset_valid", pix_valid, 0);
      check("post_reset_busy", busy, 0);
    end

    // Frame 4: full sequence again from word 0.
    push_frame();
    start_frame();
    wait_krc();
    pulse_done_all();
    wait_done("f4");

    check("frame_done_count", n_done, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
